// File: rtl/counter_from_0.sv
// counter_from_0: loads |x| as a target, counts y from 0 up to it, then holds done until acknowledged (COUNTER_FROM_0_AUTO_RELOAD_EN restarts the count instead of idling).
module counter_from_0 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic             load_x,
  output logic             load_ready,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  input  logic             done_ack
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] target;
  assign load_ready = state == IDLE;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      y <= '0;
      target <= '0;
    end else begin
      case (state)
        IDLE: if (load_x) begin
          target <= x[WIDTH-1] ? -x : x;
          y <= '0;
          state <= RUN;
        end
        RUN: if (y == target) state <= DONE;
          else if (en) y <= y + 1'b1;
        DONE: if (done_ack) begin
`ifdef COUNTER_FROM_0_AUTO_RELOAD_EN
          y <= '0;
          state <= RUN;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_from_0.sv
// tb_counter_from_0: directed self-checking bench for counter_from_0 (default and auto-reload builds).
module tb_counter_from_0;
  logic clk = 0, reset = 1, load_x = 0, en = 0, done_ack = 0;
  logic [7:0] x = '0;
  logic load_ready, busy, done;
  logic [7:0] y;
  int checks = 0, errors = 0;
  counter_from_0 #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .x(x), .load_x(load_x), .load_ready(load_ready),
    .en(en), .y(y), .busy(busy), .done(done), .done_ack(done_ack)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic [7:0] ey);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_ready"}, load_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  task automatic load(input logic [7:0] v);
    x = v;
    load_x = 1;
    tick();
    load_x = 0;
    chk("load_busy", busy, 1);
    chk("load_y", y, 0);
  endtask
  initial begin
    logic [7:0] my;
    logic md;
    load_x = 1;
    done_ack = 1;
    en = 1;
    x = 8'h22;
    tick();
    chk_idle("reset", 0);
    reset = 0;
    load_x = 0;
    done_ack = 0;
`ifdef COUNTER_FROM_0_AUTO_RELOAD_EN
    load(8'h02);
    tick(); chk("ar_y1", y, 1);
    tick(); chk("ar_y2", y, 2);
    tick(); chk("ar_done1", done, 1); chk("ar_hold", y, 2);
    done_ack = 1;
    tick();
    done_ack = 0;
    chk("ar_reload_y", y, 0); chk("ar_reload_busy", busy, 1);
    tick(); chk("ar_y1b", y, 1);
    tick(); chk("ar_y2b", y, 2); chk("ar_not_yet", done, 0);
    tick(); chk("ar_done2", done, 1); chk("ar_y_done2", y, 2);
    x = 8'h10;
    load_x = 1;
    tick();
    load_x = 0;
    chk("ar_load_ignored", done, 1); chk("ar_load_ignored_y", y, 2);
    reset = 1;
    tick();
    reset = 0;
    chk_idle("ar_reset", 0);
`else
    // x=-3: y 0,1,2,3 then done on the 5th edge counting the load edge
    en = 1;
    load(8'hFD);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("neg3_y", y, i);
      chk("neg3_busy", busy, 1);
    end
    tick(); chk("neg3_done", done, 1); chk("neg3_y_done", y, 3);
    en = 0;
    tick(); chk("neg3_hold_done", done, 1); chk("neg3_hold_y", y, 3);
    done_ack = 1;
    tick();
    done_ack = 0;
    chk_idle("neg3_ack", 3);
    load(8'h05);
    my = 0;
    md = 0;
    for (int k = 0; k < 12; k++) begin
      en = (k % 2) == 0;
      tick();
      if (my == 5) md = 1;
      else if (en) my++;
      chk("en_tog_y", y, my);
      chk("en_tog_done", done, md);
    end
    done_ack = 1;
    tick();
    done_ack = 0;
    chk_idle("en_tog_ack", 5);
    en = 1;
    done_ack = 1;
    load(8'h00);
    done_ack = 0;
    tick(); chk("zero_done", done, 1); chk("zero_busy", busy, 0); chk("zero_y", y, 0);
    done_ack = 1;
    tick();
    done_ack = 0;
    chk_idle("zero_ack", 0);
    load(8'h80);
    for (int i = 0; i < 128; i++) tick();
    chk("min_y", y, 8'h80); chk("min_busy", busy, 1);
    tick(); chk("min_done", done, 1); chk("min_y_done", y, 8'h80);
    tick(); chk("min_nowrap", y, 8'h80);
    done_ack = 1;
    tick();
    done_ack = 0;
    load(8'h03);
    tick(); chk("ign_y1", y, 1);
    x = 8'h10;
    load_x = 1;
    done_ack = 1;
    tick();
    load_x = 0;
    done_ack = 0;
    chk("ign_y2", y, 2); chk("ign_busy", busy, 1);
    tick(); chk("ign_y3", y, 3);
    tick(); chk("ign_done", done, 1); chk("ign_y_done", y, 3);
    done_ack = 1;
    tick();
    done_ack = 0;
    load(8'h03);
    tick(); chk("mid_y1", y, 1);
    reset = 1;
    tick();
    reset = 0;
    chk_idle("mid_reset", 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
